data_memory_responder: RTL



---
 rtl/data_memory_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle word-addressed data memory behind a
// valid/ready request channel with a one-cycle response pulse and a stall
// flag that stays high while an access is in flight.
module data_memory_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        requestValid,
    input  logic        requestWrite,
    input  logic [31:0] requestAddress,
    input  logic [31:0] requestWriteData,
    input  logic [3:0]  requestByteEnable,
    output logic        requestReady,
    output logic        responseValid,
    output logic [31:0] responseReadData,
    output logic        responseError,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic        enter_respond;
    logic        acc_write;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_fault;
    logic [ADDR_WIDTH-1:0] acc_index;
    logic        mem_we;

    logic [31:0] mem [DEPTH];

    // Next-state logic: capture the request in IDLE, count down in WAIT.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        enter_respond = 1'b0;
        case (state_q)
            IDLE: begin
                if (requestValid) begin
                    write_d = requestWrite;
                    addr_d  = requestAddress;
                    wdata_d = requestWriteData;
                    be_d    = requestByteEnable;
                    if (LATENCY == 1) begin
                        state_d       = RESPOND;
                        enter_respond = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d       = RESPOND;
                    enter_respond = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access operands: with LATENCY=1 the access completes on the accepting
    // edge, so the live request bus is used instead of the captured copy.
    always_comb begin
        if (state_q == IDLE) begin
            acc_write = requestWrite;
            acc_addr  = requestAddress;
            acc_wdata = requestWriteData;
            acc_be    = requestByteEnable;
        end else begin
            acc_write = write_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_fault = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
        acc_index = acc_addr[ADDR_WIDTH+1:2];
    end

    // Response values, registered on the edge that enters RESPOND.
    always_comb begin
        rsp_valid_d = enter_respond;
        rsp_err_d   = enter_respond && acc_fault;
        rsp_data_d  = '0;
        if (enter_respond && !acc_write && !acc_fault) begin
            rsp_data_d = mem[acc_index];
        end
        mem_we = enter_respond && acc_write && !acc_fault && !reset;
    end

    // State, capture and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-lane store into the (unreset) memory array.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_index][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Outputs derived from state and response registers.
    always_comb begin
        requestReady     = (state_q == IDLE);
        stall            = (state_q != IDLE);
        responseValid    = rsp_valid_q;
        responseReadData = rsp_data_q;
        responseError    = rsp_err_q;
    end

endmodule
